// File: rtl/calc_control_unit_pkg.sv
// Shared definitions for the add/sub calculator: state encoding, operation codes
// and the signed-overflow rule used when a result is computed.
package calc_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_LOAD_A  = 2'b00;
    localparam logic [1:0] ST_LOAD_B  = 2'b01;
    localparam logic [1:0] ST_COMPUTE = 2'b10;
    localparam logic [1:0] ST_SHOW    = 2'b11;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        LOAD_A  = ST_LOAD_A,
        LOAD_B  = ST_LOAD_B,
        COMPUTE = ST_COMPUTE,
        SHOW    = ST_SHOW
    } calc_state_e;

    // Overflow from operand/result sign bits only, so it is width independent.
    function automatic logic calc_ovf(input logic op, input logic sign_a,
                                      input logic sign_b, input logic sign_r);
        if (op == OP_SUB) begin
            return (sign_a != sign_b) && (sign_r != sign_a);
        end
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

endpackage

// File: rtl/calc_control_unit_if.sv
// Board-side signal bundle of the calculator: raw switches/keys in, display values out.
interface calc_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] sw_operand;
    logic             op_sel;
    logic             key_enter_n;
    logic             key_clear_n;
    logic [WIDTH-1:0] disp_value;
    logic             result_valid;
    logic             overflow;
    logic [1:0]       state_leds;

    modport master (
        output sw_operand, op_sel, key_enter_n, key_clear_n,
        input  disp_value, result_valid, overflow, state_leds
    );

    modport slave (
        input  sw_operand, op_sel, key_enter_n, key_clear_n,
        output disp_value, result_valid, overflow, state_leds
    );
endinterface

// File: rtl/calc_control_unit_key_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stable-level filter and a one-cycle
// pulse when the filtered (active-low) key goes from released to pressed.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n_i,
    output logic press_o
);
    localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        filt_d  = filt_q;
        press_d = 1'b0;
        if (sync2_q == filt_q) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
            filt_d  = sync2_q;
            cnt_d   = CNT_LOAD;
            press_d = filt_q & ~sync2_q;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Filter starts in the "pressed" level so a key held through reset must be
    // released and pressed again before it produces a pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= CNT_LOAD;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/calc_control_unit.sv
// Operand-entry and compute sequencer of the two-function calculator: captures A and B
// on ENTER, computes A+B or A-B once, and shows the registered result until the next ENTER.
//
//   state   | meaning
//   LOAD_A  | live switches shown, ENTER captures operand A
//   LOAD_B  | live switches shown, ENTER captures operand B and operation
//   COMPUTE | single cycle, result and overflow registered
//   SHOW    | result shown with result_valid, ENTER returns to LOAD_A
module calc_control_unit
    import calc_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input logic   clk,
    input logic   reset_n,
    calc_if.slave bus
);
    logic [WIDTH-1:0] sw_s1_q, sw_sync_q;
    logic             op_s1_q, op_sync_q;
    logic             enter_press, clear_press;

    calc_state_e      state_q, state_d;
    logic [WIDTH-1:0] reg_a_q, reg_a_d;
    logic [WIDTH-1:0] reg_b_q, reg_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             reg_op_q, reg_op_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] alu_w;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n_i (bus.key_enter_n),
        .press_o (enter_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n_i (bus.key_clear_n),
        .press_o (clear_press)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_s1_q   <= '0;
            sw_sync_q <= '0;
            op_s1_q   <= 1'b0;
            op_sync_q <= 1'b0;
        end else begin
            sw_s1_q   <= bus.sw_operand;
            sw_sync_q <= sw_s1_q;
            op_s1_q   <= bus.op_sel;
            op_sync_q <= op_s1_q;
        end
    end

    assign alu_w = (reg_op_q == OP_SUB) ? (reg_a_q - reg_b_q) : (reg_a_q + reg_b_q);

    always_comb begin
        state_d  = state_q;
        reg_a_d  = reg_a_q;
        reg_b_d  = reg_b_q;
        reg_op_d = reg_op_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        // Clear dominates everything, including an ENTER in the same cycle.
        if (clear_press) begin
            state_d  = LOAD_A;
            reg_a_d  = '0;
            reg_b_d  = '0;
            result_d = '0;
            ovf_d    = 1'b0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (enter_press) begin
                        reg_a_d = sw_sync_q;
                        state_d = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (enter_press) begin
                        reg_b_d  = sw_sync_q;
                        reg_op_d = op_sync_q;
                        state_d  = COMPUTE;
                    end
                end
                COMPUTE: begin
                    result_d = alu_w;
                    ovf_d    = calc_ovf(reg_op_q, reg_a_q[WIDTH-1], reg_b_q[WIDTH-1],
                                        alu_w[WIDTH-1]);
                    state_d  = SHOW;
                end
                SHOW: begin
                    if (enter_press) begin
                        ovf_d   = 1'b0;
                        state_d = LOAD_A;
                    end
                end
                default: state_d = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= LOAD_A;
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            reg_op_q <= OP_ADD;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            reg_a_q  <= reg_a_d;
            reg_b_q  <= reg_b_d;
            reg_op_q <= reg_op_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.disp_value   = (state_q == SHOW) ? result_q : sw_sync_q;
    assign bus.result_valid = (state_q == SHOW);
    assign bus.overflow     = ovf_q;
    assign bus.state_leds   = state_q;

endmodule

// File: tb/tb_calc_control_unit.sv
// Self-checking bench for calc_control_unit: directed scenarios plus randomized
// operand/op sequences compared against an arithmetic model of the calculator.
module tb_calc_control_unit;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    // Model: 0 = LOAD_A, 1 = LOAD_B, 3 = SHOW (compute is transient)
    int         m_st;
    logic [7:0] m_a, m_b;
    logic       m_op;

    calc_if #(.WIDTH(8)) bus ();

    calc_control_unit #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int model_sum();
        int sa, sb;
        sa = $signed(m_a);
        sb = $signed(m_b);
        return m_op ? (sa - sb) : (sa + sb);
    endfunction

    task automatic check_all(input string tag);
        int sum;
        int exp_disp;
        sum      = model_sum();
        exp_disp = (m_st == 3) ? (sum & 255) : int'(bus.sw_operand);
        check_val({tag, ".leds"},  int'(bus.state_leds),   m_st);
        check_val({tag, ".disp"},  int'(bus.disp_value),   exp_disp);
        check_val({tag, ".valid"}, int'(bus.result_valid), (m_st == 3) ? 1 : 0);
        check_val({tag, ".ovf"},   int'(bus.overflow),
                  (m_st == 3 && (sum > 127 || sum < -128)) ? 1 : 0);
    endtask

    task automatic model_enter();
        case (m_st)
            0: begin m_a = bus.sw_operand; m_st = 1; end
            1: begin m_b = bus.sw_operand; m_op = bus.op_sel; m_st = 3; end
            default: m_st = 0;
        endcase
    endtask

    task automatic model_clear();
        m_st = 0; m_a = 8'd0; m_b = 8'd0;
    endtask

    task automatic push_enter();
        bus.key_enter_n = 1'b0;
        tick(12);
        bus.key_enter_n = 1'b1;
        tick(12);
        model_enter();
    endtask

    task automatic run_calc(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic op);
        bus.sw_operand = a;
        tick(4);
        check_all({tag, ".loada"});
        push_enter();
        bus.sw_operand = b;
        bus.op_sel     = op;
        tick(4);
        check_all({tag, ".loadb"});
        push_enter();
        check_all({tag, ".show"});
        bus.op_sel     = ~op;
        bus.sw_operand = 8'($urandom_range(0, 255));
        tick(6);
        check_all({tag, ".hold"});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_st = 0; m_a = 8'd0; m_b = 8'd0; m_op = 1'b0;
        reset_n         = 1'b0;
        bus.sw_operand  = 8'd0;
        bus.op_sel      = 1'b0;
        bus.key_enter_n = 1'b1;
        bus.key_clear_n = 1'b1;
        tick(3);
        check_all("reset");
        reset_n = 1'b1;
        tick(12);
        check_all("post_reset");

        run_calc("t1_add", 8'd25, 8'd17, 1'b0);
        push_enter();
        run_calc("t2_addovf", 8'd100, 8'd50, 1'b0);
        push_enter();
        run_calc("t2_subovf", 8'h80, 8'd1, 1'b1);
        push_enter();
        run_calc("t3_sub", 8'd5, 8'd9, 1'b1);
        push_enter();
        bus.sw_operand = 8'd77;
        tick(4);
        check_all("t3_back");

        // Bounce: toggle every 2 clk for 20 clk, then hold low 1000 clk
        bus.key_enter_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(2);
            bus.key_enter_n = ~bus.key_enter_n;
        end
        bus.key_enter_n = 1'b0;
        tick(1000);
        model_enter();
        check_all("t4_bounce_hold");
        bus.key_enter_n = 1'b1;
        tick(12);
        check_all("t4_release");

        // Simultaneous enter + clear in LOAD_B
        bus.sw_operand  = 8'd7;
        tick(4);
        bus.key_enter_n = 1'b0;
        bus.key_clear_n = 1'b0;
        tick(12);
        bus.key_enter_n = 1'b1;
        bus.key_clear_n = 1'b1;
        tick(12);
        model_clear();
        check_all("t5_simul");

        // Clear arriving exactly during COMPUTE
        bus.sw_operand = 8'd3;
        tick(4);
        push_enter();
        bus.sw_operand  = 8'd4;
        tick(4);
        bus.key_enter_n = 1'b0;
        tick(1);
        bus.key_clear_n = 1'b0;
        tick(12);
        bus.key_enter_n = 1'b1;
        tick(1);
        bus.key_clear_n = 1'b1;
        tick(12);
        model_clear();
        check_all("t5_clr_compute");

        // Reset in SHOW with ENTER held
        run_calc("t6_pre", 8'd10, 8'd20, 1'b0);
        bus.key_enter_n = 1'b0;
        tick(2);
        reset_n = 1'b0;
        model_clear();
        m_op = 1'b0;
        tick(1);
        check_val("t6_rst.leds",  int'(bus.state_leds),   0);
        check_val("t6_rst.valid", int'(bus.result_valid), 0);
        check_val("t6_rst.ovf",   int'(bus.overflow),     0);
        reset_n = 1'b1;
        tick(50);
        check_all("t6_held");
        bus.key_enter_n = 1'b1;
        tick(12);
        check_all("t6_released");
        push_enter();
        check_all("t6_repress");
        push_enter();
        push_enter();

        // Randomized sequences against the arithmetic model
        for (int it = 0; it < 25; it++) begin
            logic [7:0] ra, rb;
            logic       rop;
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rop = 1'($urandom_range(0, 1));
            if (it % 3 == 0) begin
                ra = (it % 2 == 0) ? 8'h7F : 8'h80;
            end
            run_calc("rand", ra, rb, rop);
            push_enter();
            check_all("rand_back");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
